// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cu_pkg
// Description : Shared definitions for the control unit. Holds the opcode
//               constants, the instruction-class and sequencer-state enums,
//               and the ALU operation codes that the sequencer drives.
// Revision    : 1.0 - initial release
// ============================================================================
package cu_pkg;

    // Opcodes, taken from ir[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    // ALU operation codes share the opcode encoding of the matching instruction
    localparam logic [4:0] ALU_ADD = OP_ADD;
    localparam logic [4:0] ALU_AND = OP_AND;
    localparam logic [4:0] ALU_OR  = OP_OR;

    typedef enum logic [3:0] {
        CLS_ALU3, CLS_ALUI, CLS_LDI, CLS_LD, CLS_ST, CLS_MULDIV,
        CLS_UNARY, CLS_BR, CLS_JR, CLS_MFHL, CLS_NOP, CLS_HALT
    } cls_t;

    typedef enum logic [3:0] {
        S_RST, S_F0, S_F1, S_F2, S_F3,
        S_E0, S_E1, S_E2, S_E3, S_E4, S_HALT
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cu_decode.sv
`default_nettype none
// ============================================================================
// Module      : cu_decode
// Description : Combinational opcode decoder. Maps the 5-bit opcode to an
//               instruction class and the ALU operation used in execute.
// Ports       : opcode_i - ir[31:27]
//               cls_o    - instruction class (undefined opcodes -> CLS_NOP)
//               alu_op_o - ALU operation for the computing execute step
// Revision    : 1.0 - initial release
// ============================================================================
module cu_decode
    import cu_pkg::*;
(
    input  logic [4:0] opcode_i,
    output cls_t       cls_o,
    output logic [4:0] alu_op_o
);

    always_comb begin
        cls_o    = CLS_NOP;
        alu_op_o = ALU_ADD;
        case (opcode_i)
            OP_LD:   cls_o = CLS_LD;
            OP_LDI:  cls_o = CLS_LDI;
            OP_ST:   cls_o = CLS_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
                cls_o    = CLS_ALU3;
                alu_op_o = opcode_i;
            end
            OP_ADDI: cls_o = CLS_ALUI;
            OP_ANDI: begin cls_o = CLS_ALUI; alu_op_o = ALU_AND; end
            OP_ORI:  begin cls_o = CLS_ALUI; alu_op_o = ALU_OR;  end
            OP_MUL, OP_DIV: begin
                cls_o    = CLS_MULDIV;
                alu_op_o = opcode_i;
            end
            OP_NEG, OP_NOT: begin
                cls_o    = CLS_UNARY;
                alu_op_o = opcode_i;
            end
            OP_BR:   cls_o = CLS_BR;
            OP_JR:   cls_o = CLS_JR;
            OP_MFHI, OP_MFLO: cls_o = CLS_MFHL;
            OP_HALT: cls_o = CLS_HALT;
            default: cls_o = CLS_NOP;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Hardwired Moore sequencer for the 32-bit bus datapath.
//               Fetches through MAR/MDR, decodes ir[31:27] and steps through
//               the per-class execute states, driving every datapath strobe.
// Ports       : clk, clr (async active-low reset)
//               ir, con_ff, mem_ready, stop      - status inputs
//               *out                              - bus-drive strobes
//               *in                               - register-load strobes
//               IncPC, Read, Write                - PC / memory strobes
//               Gra, Grb, Grc, Rin, Rout, BAout   - register-select strobes
//               operation, branch_flag            - ALU control
//               run                               - high outside RST/HALT
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import cu_pkg::*;
#(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout,
    output logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin, OutPortin,
    output logic        IncPC, Read, Write,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout,
    output logic [4:0]  operation,
    output logic        branch_flag,
    output logic        run
);

    localparam logic [1:0] HOLD_LAST = 2'(RESET_PC_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] hold_q, hold_d;
    cls_t       cls;
    logic [4:0] alu_op;
    logic       w_unused_ir;

    // Only the opcode field matters to the sequencer
    assign w_unused_ir = ^ir[26:0];

    cu_decode u_decode (
        .opcode_i (ir[31:27]),
        .cls_o    (cls),
        .alu_op_o (alu_op)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_RST;
            hold_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic; wait states simply hold until mem_ready
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            S_RST:  if (hold_q == HOLD_LAST) state_d = S_F0;
                    else hold_d = hold_q + 2'd1;
            S_F0:   state_d = stop ? S_HALT : S_F1;
            S_F1:   state_d = S_F2;
            S_F2:   if (mem_ready) state_d = S_F3;
            S_F3:   state_d = S_E0;
            S_E0:   case (cls)
                        CLS_HALT:                   state_d = S_HALT;
                        CLS_JR, CLS_MFHL, CLS_NOP:  state_d = S_F0;
                        default:                    state_d = S_E1;
                    endcase
            S_E1:   state_d = (cls == CLS_UNARY) ? S_F0 : S_E2;
            S_E2:   case (cls)
                        CLS_LD, CLS_ST, CLS_MULDIV, CLS_BR: state_d = S_E3;
                        default:                            state_d = S_F0;
                    endcase
            S_E3:   case (cls)
                        CLS_LD:  if (mem_ready) state_d = S_E4;
                        CLS_ST:  state_d = S_E4;
                        default: state_d = S_F0;
                    endcase
            S_E4:   if (cls != CLS_ST || mem_ready) state_d = S_F0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // Moore outputs: everything low by default, operation idles at add
    always_comb begin
        {PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout} = '0;
        {MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin, OutPortin} = '0;
        {IncPC, Read, Write} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
        operation   = ALU_ADD;
        branch_flag = 1'b0;
        run         = (state_q != S_RST) && (state_q != S_HALT);
        case (state_q)
            S_F0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1; end
            S_F1: begin ZLowout = 1'b1; PCin = 1'b1; end
            S_F2: begin Read = 1'b1; MDRin = 1'b1; end
            S_F3: begin MDRout = 1'b1; IRin = 1'b1; end
            S_E0: case (cls)
                CLS_ALU3, CLS_ALUI:     begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                CLS_LDI, CLS_LD, CLS_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                CLS_MULDIV:             begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                CLS_UNARY: begin Grb = 1'b1; Rout = 1'b1; ZLOin = 1'b1; operation = alu_op; end
                CLS_BR:                 begin Grb = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                CLS_JR:                 begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                CLS_MFHL: begin
                    HIout = (ir[31:27] == OP_MFHI);
                    LOout = (ir[31:27] != OP_MFHI);
                    Gra   = 1'b1;
                    Rin   = 1'b1;
                end
                default: ;
            endcase
            S_E1: case (cls)
                CLS_ALU3: begin Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; operation = alu_op; end
                CLS_ALUI, CLS_LDI, CLS_LD, CLS_ST: begin
                    Cout = 1'b1; ZLOin = 1'b1; operation = alu_op;
                end
                CLS_MULDIV: begin
                    Grb = 1'b1; Rout = 1'b1; ZHIin = 1'b1; ZLOin = 1'b1; operation = alu_op;
                end
                CLS_UNARY: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                CLS_BR:    begin PCout = 1'b1; Yin = 1'b1; end
                default: ;
            endcase
            S_E2: case (cls)
                CLS_ALU3, CLS_ALUI, CLS_LDI: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                CLS_LD, CLS_ST: begin ZLowout = 1'b1; MARin = 1'b1; end
                CLS_MULDIV:     begin ZLowout = 1'b1; LOin = 1'b1; end
                CLS_BR:         begin Cout = 1'b1; ZLOin = 1'b1; branch_flag = 1'b1; end
                default: ;
            endcase
            S_E3: case (cls)
                CLS_LD:     begin Read = 1'b1; MDRin = 1'b1; end
                CLS_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                CLS_MULDIV: begin ZHighout = 1'b1; HIin = 1'b1; end
                CLS_BR:     begin ZLowout = con_ff; PCin = con_ff; end
                default: ;
            endcase
            S_E4: case (cls)
                CLS_LD:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                CLS_ST:  Write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Self-checking bench for control_unit. Each instruction is
//               expanded into the list of strobe sets it should produce,
//               cycle by cycle, and the DUT is compared against that list
//               under random memory wait states, stop noise and branch
//               conditions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    localparam int HOLD = 1;
    localparam logic [4:0] ADD = 5'b00011;

    typedef logic [29:0] vec_t;
    localparam vec_t M_PCOUT  = 30'd1 << 29, M_ZHOUT  = 30'd1 << 28, M_ZLOUT  = 30'd1 << 27;
    localparam vec_t M_MDROUT = 30'd1 << 26, M_HIOUT  = 30'd1 << 25, M_LOOUT  = 30'd1 << 24;
    localparam vec_t M_COUT   = 30'd1 << 22, M_MARIN  = 30'd1 << 21, M_PCIN   = 30'd1 << 20;
    localparam vec_t M_MDRIN  = 30'd1 << 19, M_IRIN   = 30'd1 << 18, M_YIN    = 30'd1 << 17;
    localparam vec_t M_HIIN   = 30'd1 << 16, M_LOIN   = 30'd1 << 15, M_ZHIIN  = 30'd1 << 14;
    localparam vec_t M_ZLOIN  = 30'd1 << 13, M_CONIN  = 30'd1 << 12, M_INCPC  = 30'd1 << 10;
    localparam vec_t M_READ   = 30'd1 << 9,  M_WRITE  = 30'd1 << 8,  M_GRA    = 30'd1 << 7;
    localparam vec_t M_GRB    = 30'd1 << 6,  M_GRC    = 30'd1 << 5,  M_RIN    = 30'd1 << 4;
    localparam vec_t M_ROUT   = 30'd1 << 3,  M_BAOUT  = 30'd1 << 2,  M_BRF    = 30'd1 << 1;
    localparam vec_t M_RUN    = 30'd1;

    typedef struct packed {
        vec_t       v;
        logic [4:0] op;
        logic       wt;
    } step_t;

    logic        clk, clr, con_ff, mem_ready, stop;
    logic [31:0] ir;
    logic        PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin, OutPortin;
    logic        IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0]  operation;
    logic        branch_flag, run;

    vec_t        obs;
    logic [9:0]  drv;
    step_t       prog[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    assign obs = {PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout,
                  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin, OutPortin,
                  IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, branch_flag, run};
    assign drv = {PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout, Rout, BAout};

    control_unit #(.RESET_PC_HOLD(HOLD)) dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready), .stop(stop),
        .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
        .LOin(LOin), .ZHIin(ZHIin), .ZLOin(ZLOin), .CONin(CONin), .OutPortin(OutPortin),
        .IncPC(IncPC), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .operation(operation), .branch_flag(branch_flag), .run(run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push(input vec_t v, input logic [4:0] op, input logic wt);
        step_t s;
        s.v  = v | M_RUN;
        s.op = op;
        s.wt = wt;
        prog.push_back(s);
    endfunction

    // Expected strobe list for one instruction, straight from the instruction table
    function automatic void build(input logic [4:0] opc, input logic cf);
        prog.delete();
        push(M_PCOUT | M_MARIN | M_INCPC | M_ZLOIN, ADD, 1'b0);
        push(M_ZLOUT | M_PCIN, ADD, 1'b0);
        push(M_READ | M_MDRIN, ADD, 1'b1);
        push(M_MDROUT | M_IRIN, ADD, 1'b0);
        if (opc >= 5'd3 && opc <= 5'd10) begin
            push(M_GRB | M_ROUT | M_YIN, ADD, 1'b0);
            push(M_GRC | M_ROUT | M_ZLOIN, opc, 1'b0);
            push(M_ZLOUT | M_GRA | M_RIN, ADD, 1'b0);
        end else if (opc >= 5'd11 && opc <= 5'd13) begin
            push(M_GRB | M_ROUT | M_YIN, ADD, 1'b0);
            push(M_COUT | M_ZLOIN, (opc == 5'd11) ? 5'b00011 : (opc == 5'd12) ? 5'b00101 : 5'b00110, 1'b0);
            push(M_ZLOUT | M_GRA | M_RIN, ADD, 1'b0);
        end else if (opc <= 5'd2) begin
            push(M_GRB | M_BAOUT | M_YIN, ADD, 1'b0);
            push(M_COUT | M_ZLOIN, ADD, 1'b0);
            if (opc == 5'd1) push(M_ZLOUT | M_GRA | M_RIN, ADD, 1'b0);
            else begin
                push(M_ZLOUT | M_MARIN, ADD, 1'b0);
                if (opc == 5'd0) begin
                    push(M_READ | M_MDRIN, ADD, 1'b1);
                    push(M_MDROUT | M_GRA | M_RIN, ADD, 1'b0);
                end else begin
                    push(M_GRA | M_ROUT | M_MDRIN, ADD, 1'b0);
                    push(M_WRITE, ADD, 1'b1);
                end
            end
        end else if (opc == 5'd14 || opc == 5'd15) begin
            push(M_GRA | M_ROUT | M_YIN, ADD, 1'b0);
            push(M_GRB | M_ROUT | M_ZHIIN | M_ZLOIN, opc, 1'b0);
            push(M_ZLOUT | M_LOIN, ADD, 1'b0);
            push(M_ZHOUT | M_HIIN, ADD, 1'b0);
        end else if (opc == 5'd16 || opc == 5'd17) begin
            push(M_GRB | M_ROUT | M_ZLOIN, opc, 1'b0);
            push(M_ZLOUT | M_GRA | M_RIN, ADD, 1'b0);
        end else if (opc == 5'd18) begin
            push(M_GRB | M_ROUT | M_CONIN, ADD, 1'b0);
            push(M_PCOUT | M_YIN, ADD, 1'b0);
            push(M_COUT | M_ZLOIN | M_BRF, ADD, 1'b0);
            push(cf ? (M_ZLOUT | M_PCIN) : 30'd0, ADD, 1'b0);
        end else if (opc == 5'd19) push(M_GRA | M_ROUT | M_PCIN, ADD, 1'b0);
        else if (opc == 5'd23) push(M_HIOUT | M_GRA | M_RIN, ADD, 1'b0);
        else if (opc == 5'd24) push(M_LOOUT | M_GRA | M_RIN, ADD, 1'b0);
        else push(30'd0, ADD, 1'b0);   // nop, halt E0 and undefined opcodes
    endfunction

    // Called at a negedge with the DUT in F0; returns at the negedge of the next F0.
    // abort_at >= 0 pulls clr low mid-cycle once that step is reached.
    task automatic run_instr(input logic [31:0] word, input logic cf, input int force_wait,
                             input int abort_at);
        int i      = 0;
        int waited = 0;
        build(word[31:27], cf);
        ir     = word;
        con_ff = cf;
        while (i < prog.size()) begin
            stop = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            check($sformatf("op%0d_step%0d_strobes", word[31:27], i), 32'(obs), 32'(prog[i].v));
            check($sformatf("op%0d_step%0d_operation", word[31:27], i), 32'(operation), 32'(prog[i].op));
            check("one_bus_drive", 32'($countones(drv) > 1), 32'd0);
            check("read_write_excl", 32'(Read & Write), 32'd0);
            if (i == abort_at) begin
                mem_ready = 1'b0;
                @(posedge clk);
                #2 clr = 1'b0;
                #1;
                check("async_clr_strobes", 32'(obs), 32'd0);
                check("async_clr_operation", 32'(operation), 32'(ADD));
                return;
            end
            if (prog[i].wt) begin
                if (i >= 4 && waited < force_wait) mem_ready = 1'b0;
                else if (waited >= 3)              mem_ready = 1'b1;
                else                               mem_ready = 1'($urandom_range(0, 1));
                if (mem_ready) begin i++; waited = 0; end
                else waited++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                i++;
            end
            @(negedge clk);
        end
    endtask

    // Leaves the bench at a negedge with the DUT in F0
    task automatic do_reset();
        clr       = 1'b0;
        stop      = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_async", 32'(obs), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst_strobes", 32'(obs), 32'd0);
            check("rst_operation", 32'(operation), 32'(ADD));
        end
        clr = 1'b1;
        for (int k = 0; k < HOLD; k++) begin
            if (k > 0) @(negedge clk);
            check("rst_hold", 32'(obs), 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic check_halted(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            stop      = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            check("halt_strobes", 32'(obs), 32'd0);
            check("halt_operation", 32'(operation), 32'(ADD));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [4:0] opc;
        clr = 1'b1; stop = 1'b0; mem_ready = 1'b1; con_ff = 1'b0; ir = 32'd0;
        #2;
        do_reset();

        run_instr(32'hC8000000, 1'b0, 0, -1);   // nop
        run_instr(32'h18918000, 1'b0, 0, -1);   // add R1,R2,R3
        run_instr(32'h00800010, 1'b0, 3, -1);   // ld with 3 wait cycles in E3
        run_instr(32'h90800004, 1'b0, 0, -1);   // br, not taken
        run_instr(32'h90800004, 1'b1, 0, -1);   // br, taken
        run_instr(32'h70880000, 1'b0, 0, -1);   // mul
        run_instr(32'h10800020, 1'b0, 2, -1);   // st with waits

        for (int n = 0; n < 60; n++) begin
            opc = 5'($urandom_range(0, 31));
            if (opc == 5'b11010) opc = 5'b11001;
            run_instr({opc, 27'($urandom)}, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), -1);
        end

        run_instr(32'hD0000000, 1'b0, 0, -1);   // halt
        check_halted(20);

        do_reset();
        stop = 1'b1;                             // stop sampled in F0
        check("stop_f0_strobes", 32'(obs), 32'(M_PCOUT | M_MARIN | M_INCPC | M_ZLOIN | M_RUN));
        @(negedge clk);
        stop = 1'b0;
        check_halted(5);

        do_reset();
        run_instr(32'h00800010, 1'b0, 0, 7);     // clr drops during ld E3
        do_reset();
        run_instr(32'hC8000000, 1'b0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore sequencer for the 32-bit bus datapath.
- Fetches the instruction word via MAR/MDR, decodes opcode ir[31:27], and steps through per-class execute states.
- Drives every bus-drive, register-load, ALU-op and memory strobe the datapath exposes.
- Sits beside the datapath and holds the register-select strobes (Gra/Grb/Grc/Rin/Rout/BAout) for the select/encode logic.

Parameters:
- RESET_PC_HOLD, 1, cycles spent in RST after clr deasserts before the first fetch (1..3).

Ports:
- clk  input  1  system clock, rising edge
- clr  input  1  asynchronous, active-low reset
- ir  input  32  instruction register contents
- con_ff  input  1  branch-condition flip-flop value
- mem_ready  input  1  memory handshake: read data valid / write accepted this cycle
- stop  input  1  halt request, sampled only in F0
- PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout  output  1 each  bus-drive strobes
- MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin, OutPortin  output  1 each  register-load strobes
- IncPC, Read, Write  output  1 each  PC-increment / memory strobes
- Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-select strobes
- operation  output  5  ALU opcode
- branch_flag  output  1  ALU branch-add mode
- run  output  1  high while not in RST/HALT

Behaviour:
- clr low: state=RST immediately, mid-instruction included. All outputs 0, operation=5'b00011 (add).
- After clr rises: RESET_PC_HOLD cycles in RST, then F0, run=1. Outputs are a pure function of state (Moore).
- Opcodes (5-bit):
  - ld=00000, ldi=00001, st=00010
  - add=00011, sub=00100, and=00101, or=00110, shr=00111, shl=01000, ror=01001, rol=01010
  - addi=01011, andi=01100, ori=01101
  - mul=01110, div=01111, neg=10000, not=10001
  - br=10010, jr=10011, mfhi=10111, mflo=11000, nop=11001, halt=11010
  - Undefined opcodes behave as nop.
- Fetch:
  - F0: PCout, MARin, IncPC, ZLOin. If stop=1, go to HALT instead of F1.
  - F1: ZLowout, PCin.
  - F2: Read, MDRin. Hold F2 with both asserted until mem_ready=1.
  - F3: MDRout, IRin.
  - Next state is E0; the class is decoded from ir in E0.
- Execute (last listed step returns to F0):
  - ALU3 (add..rol): E0 Grb,Rout,Yin; E1 Grc,Rout,ZLOin, operation=opcode; E2 ZLowout,Gra,Rin.
  - ALUI (addi/andi/ori): E0 Grb,Rout,Yin; E1 Cout,ZLOin, operation=add/and/or respectively; E2 ZLowout,Gra,Rin.
  - ldi: E0 Grb,BAout,Yin; E1 Cout,ZLOin, operation=add; E2 ZLowout,Gra,Rin.
  - ld: E0–E1 as ldi; E2 ZLowout,MARin; E3 Read,MDRin (wait mem_ready); E4 MDRout,Gra,Rin.
  - st: E0–E2 as ld; E3 Gra,Rout,MDRin (Read=0); E4 Write (wait mem_ready).
  - mul/div: E0 Gra,Rout,Yin; E1 Grb,Rout,ZHIin,ZLOin, operation=opcode; E2 ZLowout,LOin; E3 ZHighout,HIin.
  - neg/not: E0 Grb,Rout,ZLOin, operation=opcode; E1 ZLowout,Gra,Rin.
  - br: E0 Grb,Rout,CONin; E1 PCout,Yin; E2 Cout,ZLOin, operation=add, branch_flag=1; E3 ZLowout,PCin only if con_ff=1, otherwise no strobes.
  - jr: E0 Gra,Rout,PCin.
  - mfhi/mflo: E0 HIout/LOout,Gra,Rin.
  - nop: E0 no strobes.
  - halt: E0 goes to HALT.
- HALT: all strobes 0, run=0. Exits only via clr.
- Invariants:
  - At most one bus-drive strobe high per cycle (bench asserts this).
  - Read and Write are never both high.
  - Wait states hold all strobes of that state unchanged.
  - When waiting on mem_ready, there is no timeout.
  - stop asserted outside F0 is ignored until the next F0.

Decomposition:
- Package cu_pkg holds the opcode constants, instruction-class enum (ALU3, ALUI, LDI, LD, ST, MULDIV, UNARY, BR, JR, MFHL, NOP, HALT), state enum (RST, F0–F3, E0–E4, HALT) and the ALU op encodings.
- One combinational sub-module, cu_decode, maps opcode to class and ALU operation.
- Sequencer and output logic stay in control_unit.

Test Plan:
- Reset/fetch: clr low 3 cycles, release, mem_ready=1, ir=32'hC8000000 (nop). Expect all outputs 0 in RST; F0 PCout/MARin/IncPC/ZLOin; F3 IRin; back to F0 after 6 cycles; run=1.
- ALU3 add: ir=32'h18918000 (add R1,R2,R3). Expect E1 operation=00011 with Grc,Rout,ZLOin; E2 ZLowout,Gra,Rin; 7 cycles total.
- Load with wait: ld, mem_ready low 3 cycles in E3. Expect Read/MDRin held 4 cycles, then E4 MDRout,Gra,Rin; no two bus drives high in any cycle.
- Branch: br with con_ff=0, then con_ff=1. Expect E3 with no strobes vs ZLowout+PCin; branch_flag=1 only in E2.
- mul: expect E1 ZHIin&ZLOin with operation=01110, E2 LOin, E3 HIin.
- halt/stop/reset mid-op: opcode 11010 gives run=0 and HALT sticky for 20 cycles; stop=1 in F0 also halts; clr pulled low during E3 of ld returns all outputs to 0 asynchronously, before the next clk edge.
